// File: rtl/clk_div_bank.sv
// Bank of phase-aligned integer clock dividers on a single reference clock.
// Optional per-channel phase offsets are enabled with `define CLK_DIV_BANK_PHASE_EN.
module clk_div_bank #(
   parameter int unsigned NUM_CLOCKS  = 4,
   parameter int unsigned DIV_WIDTH   = 16,
   parameter int unsigned DEFAULT_DIV = 10,
   parameter int unsigned LOCK_CYCLES = 16,
   localparam int unsigned CHAN_W     = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [CHAN_W-1:0]     cfg_chan,
   input  logic [DIV_WIDTH-1:0]  cfg_div,
   input  logic [DIV_WIDTH-1:0]  cfg_phase,
   output logic [NUM_CLOCKS-1:0] outclk,
   output logic [NUM_CLOCKS-1:0] outclk_en,
   output logic                  locked
);

   localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_LOCKED} state_t;

   state_t                state_q, state_d;
   logic [DIV_WIDTH-1:0]  div_q [NUM_CLOCKS];
   logic [DIV_WIDTH-1:0]  div_d [NUM_CLOCKS];
   logic [DIV_WIDTH-1:0]  cnt_q [NUM_CLOCKS];
   logic [DIV_WIDTH-1:0]  cnt_d [NUM_CLOCKS];
   logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
   logic [NUM_CLOCKS-1:0] outclk_q, outclk_d;
   logic [NUM_CLOCKS-1:0] outclk_en_q, outclk_en_d;
   logic                  locked_q, locked_d;
   logic                  cfg_ready_q, cfg_ready_d;

   logic                  accept, chan_ok, running, entering_sync;
   logic [DIV_WIDTH-1:0]  new_div;

`ifdef CLK_DIV_BANK_PHASE_EN
   logic [DIV_WIDTH-1:0]  phase_q [NUM_CLOCKS];
   logic [DIV_WIDTH-1:0]  phase_d [NUM_CLOCKS];
`else
   logic                  unused_phase;
   assign unused_phase = ^cfg_phase;
`endif

   // Next-state, configuration write and per-channel counter logic
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      lock_cnt_d  = '0;
      outclk_d    = '0;
      outclk_en_d = '0;
`ifdef CLK_DIV_BANK_PHASE_EN
      phase_d     = phase_q;
`endif

      accept  = cfg_valid && cfg_ready_q;
      chan_ok = (32'(cfg_chan) < NUM_CLOCKS);
      new_div = (cfg_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_div;

      if (accept && chan_ok) begin
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (CHAN_W'(i) == cfg_chan) begin
               div_d[i] = new_div;
`ifdef CLK_DIV_BANK_PHASE_EN
               phase_d[i] = cfg_phase;
`endif
            end
         end
      end

      // Dropping enable wins over any other transition
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   state_d = ST_SYNC;
            ST_SYNC:   if (lock_cnt_q == LOCK_W'(LOCK_CYCLES - 1)) state_d = ST_LOCKED;
            ST_LOCKED: if (accept && chan_ok) state_d = ST_SYNC;
            default:   state_d = ST_IDLE;
         endcase
      end

      running       = (state_d != ST_IDLE);
      entering_sync = (state_d == ST_SYNC) && (state_q != ST_SYNC);

      if ((state_d == ST_SYNC) && !entering_sync) lock_cnt_d = lock_cnt_q + LOCK_W'(1);

      for (int i = 0; i < NUM_CLOCKS; i++) begin
         if (!running) begin
            cnt_d[i] = '0;
         end else if (entering_sync) begin
`ifdef CLK_DIV_BANK_PHASE_EN
            cnt_d[i] = (phase_d[i] < div_d[i]) ? phase_d[i] : '0;
`else
            cnt_d[i] = '0;
`endif
         end else if (cnt_q[i] >= div_q[i] - DIV_WIDTH'(1)) begin
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + DIV_WIDTH'(1);
         end
         outclk_d[i]    = running && (cnt_d[i] < (div_d[i] >> 1));
         outclk_en_d[i] = running && (cnt_d[i] == '0);
      end

      locked_d    = (state_d == ST_LOCKED);
      cfg_ready_d = (state_d != ST_SYNC);
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         lock_cnt_q  <= '0;
         outclk_q    <= '0;
         outclk_en_q <= '0;
         locked_q    <= 1'b0;
         cfg_ready_q <= 1'b0;
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            div_q[i] <= DIV_WIDTH'(DEFAULT_DIV);
            cnt_q[i] <= '0;
`ifdef CLK_DIV_BANK_PHASE_EN
            phase_q[i] <= '0;
`endif
         end
      end else begin
         state_q     <= state_d;
         lock_cnt_q  <= lock_cnt_d;
         outclk_q    <= outclk_d;
         outclk_en_q <= outclk_en_d;
         locked_q    <= locked_d;
         cfg_ready_q <= cfg_ready_d;
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            div_q[i] <= div_d[i];
            cnt_q[i] <= cnt_d[i];
`ifdef CLK_DIV_BANK_PHASE_EN
            phase_q[i] <= phase_d[i];
`endif
         end
      end
   end

   assign outclk    = outclk_q;
   assign outclk_en = outclk_en_q;
   assign locked    = locked_q;
   assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: vector table plus hand-written corner sequences.
// A second 3-channel instance shares the bus so an out-of-range channel index is expressible.
module tb_clk_div_bank;

   logic        refclk = 1'b0;
   logic        rst, enable, cfg_valid;
   logic [1:0]  cfg_chan;
   logic [15:0] cfg_div, cfg_phase;
   logic        cfg_ready, locked, cfg_ready3, locked3;
   logic [3:0]  outclk, outclk_en;
   logic [2:0]  outclk3, outclk_en3;

   clk_div_bank u_dut (
      .refclk(refclk), .rst(rst), .enable(enable), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .cfg_chan(cfg_chan), .cfg_div(cfg_div),
      .cfg_phase(cfg_phase), .outclk(outclk), .outclk_en(outclk_en), .locked(locked)
   );

   clk_div_bank #(.NUM_CLOCKS(3)) u_dut3 (
      .refclk(refclk), .rst(rst), .enable(enable), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready3), .cfg_chan(cfg_chan), .cfg_div(cfg_div),
      .cfg_phase(cfg_phase), .outclk(outclk3), .outclk_en(outclk_en3), .locked(locked3)
   );

   always #5 refclk = ~refclk;

`ifdef CLK_DIV_BANK_PHASE_EN
   localparam int PH_OFF = 7;
`else
   localparam int PH_OFF = 0;
`endif

   typedef struct {
      logic [1:0]  chan;
      logic [15:0] div;
      logic [15:0] phase;
      int          exp_off;
      int          exp_hi;
      int          exp_lo;
   } vec_t;

   typedef struct {
      string name;
      int    value;
   } exp_t;

   vec_t vecs[5];
   exp_t sb[$];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   rise_cyc = -1;
   int   entry_cyc = 0;
   logic lk_prev = 1'b0;

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void sb_push(string name, int value);
      exp_t e;
      e.name  = name;
      e.value = value;
      sb.push_back(e);
   endfunction

   function automatic void sb_check(int act);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty: got %0d, expected nothing queued", act);
      end else begin
         e = sb.pop_front();
         chk(e.name, act, e.value);
      end
   endfunction

   // Advance to the next sampling point and track the rising edge of locked
   task automatic tick();
      @(negedge refclk);
      cyc++;
      if (locked && !lk_prev) rise_cyc = cyc;
      lk_prev = locked;
   endtask

   task automatic send_cfg(input logic [1:0] ch, input logic [15:0] d, input logic [15:0] p);
      cfg_valid = 1'b1;
      cfg_chan  = ch;
      cfg_div   = d;
      cfg_phase = p;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic measure(input logic [1:0] ch, output int off, output int hi, output int lo);
      off = 0;
      while (!outclk_en[ch] && off < 40) begin tick(); off++; end
      hi = 0;
      while (outclk[ch] && hi < 40) begin tick(); hi++; end
      lo = 0;
      while (!outclk[ch] && lo < 40) begin tick(); lo++; end
   endtask

   task automatic wait_lock();
      int w = 0;
      while (!locked && w < 100) begin tick(); w++; end
   endtask

   initial begin
      int off, hi, lo, k, bad;

      vecs[0] = '{2'd1, 16'd7,  16'd0,  0,      3, 4};
      vecs[1] = '{2'd1, 16'd1,  16'd0,  0,      1, 1};
      vecs[2] = '{2'd1, 16'd0,  16'd0,  0,      1, 1};
      vecs[3] = '{2'd2, 16'd10, 16'd3,  PH_OFF, 5, 5};
      vecs[4] = '{2'd2, 16'd10, 16'd12, 0,      5, 5};

      rst = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
      cfg_chan = '0; cfg_div = '0; cfg_phase = '0;
      tick(); tick();
      chk("rst_outclk", int'(outclk), 0);
      chk("rst_outclk_en", int'(outclk_en), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_cfg_ready", int'(cfg_ready), 0);

      rst = 1'b1;
      tick();
      chk("idle_cfg_ready", int'(cfg_ready), 1);
      chk("idle_outclk", int'(outclk), 0);

      // Defaults: divide by 10, all channels in phase, lock after 16 cycles
      enable = 1'b1;
      tick();
      entry_cyc = cyc;
      chk("sync_entry_en", int'(outclk_en), 15);
      chk("sync_entry_outclk", int'(outclk), 15);
      chk("sync_cfg_ready", int'(cfg_ready), 0);
      measure(2'd0, off, hi, lo);
      chk("def_off", off, 0);
      chk("def_hi", hi, 5);
      chk("def_lo", lo, 5);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (outclk != 4'h0 && outclk != 4'hF) bad++;
         if (outclk_en != 4'h0 && outclk_en != 4'hF) bad++;
         tick();
      end
      chk("def_in_phase", bad, 0);
      chk("def_lock_latency", rise_cyc - entry_cyc, 16);
      chk("def_locked3", int'(locked3), 1);

      // Reconfiguration vectors applied from LOCKED
      for (int v = 0; v < 5; v++) begin
         wait_lock();
         chk($sformatf("v%0d_cfg_ready", v), int'(cfg_ready), 1);
         sb_push($sformatf("v%0d_offset", v), vecs[v].exp_off);
         sb_push($sformatf("v%0d_high", v), vecs[v].exp_hi);
         sb_push($sformatf("v%0d_low", v), vecs[v].exp_lo);
         sb_push($sformatf("v%0d_lock_latency", v), 16);
         send_cfg(vecs[v].chan, vecs[v].div, vecs[v].phase);
         entry_cyc = cyc;
         chk($sformatf("v%0d_locked_drop", v), int'(locked), 0);
         chk($sformatf("v%0d_ch0_en", v), int'(outclk_en[0]), 1);
         measure(vecs[v].chan, off, hi, lo);
         sb_check(off);
         sb_check(hi);
         sb_check(lo);
         wait_lock();
         sb_check(rise_cyc - entry_cyc);
      end

      // Out-of-range channel on the 3-channel instance: no effect, stays locked
      wait_lock();
      k = 0;
      while (!outclk_en3[0] && k < 40) begin tick(); k++; end
      chk("oor_cfg_ready3", int'(cfg_ready3), 1);
      send_cfg(2'd3, 16'd7, 16'd0);
      chk("oor_locked3", int'(locked3), 1);
      chk("oor_cfg_ready3_after", int'(cfg_ready3), 1);
      chk("inrange_locked_drop", int'(locked), 0);
      k = 1;
      bad = 0;
      while (!outclk_en3[0] && k < 40) begin
         if (!locked3) bad++;
         tick();
         k++;
      end
      chk("oor_period3", k, 10);
      chk("oor_locked3_held", bad, 0);

      // Enable drop coincident with a cfg accept; the write must survive
      wait_lock();
      enable = 1'b0;
      send_cfg(2'd1, 16'd4, 16'd0);
      chk("drop_outclk", int'(outclk), 0);
      chk("drop_outclk_en", int'(outclk_en), 0);
      chk("drop_locked", int'(locked), 0);
      chk("drop_cfg_ready", int'(cfg_ready), 1);
      send_cfg(2'd3, 16'd8, 16'd0);
      chk("idle_cfg_outclk", int'(outclk), 0);
      chk("idle_cfg_ready2", int'(cfg_ready), 1);
      enable = 1'b1;
      tick();
      chk("reenable_en", int'(outclk_en), 15);
      measure(2'd1, off, hi, lo);
      chk("retained_ch1_off", off, 0);
      chk("retained_ch1_hi", hi, 2);
      chk("retained_ch1_lo", lo, 2);
      chk("retained_ch3_div8", int'(outclk[3]), 0);

      // Reset mid-SYNC returns everything to defaults
      tick();
      chk("midsync_locked", int'(locked), 0);
      rst = 1'b0;
      #1;
      chk("rst_async_outclk", int'(outclk), 0);
      chk("rst_async_en", int'(outclk_en), 0);
      chk("rst_async_ready", int'(cfg_ready), 0);
      enable = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("rst2_cfg_ready", int'(cfg_ready), 1);
      enable = 1'b1;
      tick();
      entry_cyc = cyc;
      chk("rst2_entry_en", int'(outclk_en), 15);
      measure(2'd1, off, hi, lo);
      chk("rst2_ch1_hi", hi, 5);
      chk("rst2_ch1_lo", lo, 5);
      measure(2'd3, off, hi, lo);
      chk("rst2_ch3_off", off, 0);
      chk("rst2_ch3_hi", hi, 5);
      chk("rst2_ch3_lo", lo, 5);
      wait_lock();
      chk("rst2_lock_latency", rise_cyc - entry_cyc, 16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1);
   end

endmodule
